// File: rtl/key_hex_pio.sv
// Avalon-MM KEY/HEX peripheral: debounced push-buttons with sticky press flags and maskable irq,
// plus NUM_HEX seven-segment digits in raw or hex-decode mode. Reads are 1-cycle latency; no stalls.
module key_hex_pio #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_HEX         = 6,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             address,
  input  logic                   read,
  input  logic                   write,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  output logic                   irq,
  input  logic [NUM_KEYS-1:0]    key_n,
  output logic [7*NUM_HEX-1:0]   hex_n
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1, sync2, key_sync, key_state, key_edge, irq_mask, rise, edge_clr;
  logic [CW-1:0]       cnt [NUM_KEYS];
  logic [NUM_HEX-1:0]  hex_mode, hex_mode_nxt;
  logic [6:0]          hex_data [NUM_HEX];
  logic [6:0]          hex_data_nxt [NUM_HEX];
  logic [7*NUM_HEX-1:0] hex_n_nxt;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Synchroniser resets to "released" so no phantom press appears after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign key_sync = ~sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_state <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_sync[k] == key_state[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CMAX) begin
          key_state[k] <= key_sync[k];
          cnt[k]       <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Press edge fires on the same clock the debounced state rises.
  always_comb begin
    rise = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      rise[k] = ~key_state[k] & key_sync[k] & (cnt[k] == CMAX);
  end

  assign edge_clr = (write && address == 4'd1) ? writedata[NUM_KEYS-1:0] : '0;

  always_comb begin
    hex_mode_nxt = hex_mode;
    for (int i = 0; i < NUM_HEX; i++) hex_data_nxt[i] = hex_data[i];
    if (write) begin
      if (address == 4'd3) hex_mode_nxt = writedata[NUM_HEX-1:0];
      for (int i = 0; i < NUM_HEX; i++)
        if (address == 4'(4 + i)) hex_data_nxt[i] = writedata[6:0];
    end
  end

  // Segments follow the post-write register values so the display changes one cycle after the write.
  always_comb begin
    hex_n_nxt = '0;
    for (int i = 0; i < NUM_HEX; i++)
      hex_n_nxt[7*i +: 7] = hex_mode_nxt[i] ? seg7(hex_data_nxt[i][3:0]) : hex_data_nxt[i];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      4'd0: rd_mux[NUM_KEYS-1:0] = key_state;
      4'd1: rd_mux[NUM_KEYS-1:0] = key_edge;
      4'd2: rd_mux[NUM_KEYS-1:0] = irq_mask;
      4'd3: rd_mux[NUM_HEX-1:0]  = hex_mode;
      default: begin
        for (int i = 0; i < NUM_HEX; i++)
          if (address == 4'(4 + i)) rd_mux[6:0] = hex_data[i];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_edge <= '0;
      irq_mask <= '0;
      hex_mode <= '1;
      for (int i = 0; i < NUM_HEX; i++) hex_data[i] <= '0;
      hex_n    <= {NUM_HEX{7'h40}};
      readdata <= '0;
    end else begin
      key_edge <= (key_edge & ~edge_clr) | rise;
      if (write && address == 4'd2) irq_mask <= writedata[NUM_KEYS-1:0];
      hex_mode <= hex_mode_nxt;
      for (int i = 0; i < NUM_HEX; i++) hex_data[i] <= hex_data_nxt[i];
      hex_n    <= hex_n_nxt;
      if (read) readdata <= rd_mux;
    end
  end

  assign irq = |(key_edge & irq_mask);

endmodule

// File: tb/tb_key_hex_pio.sv
// Bench for key_hex_pio: directed corner sequences, a hex-decode vector table, and random traffic
// checked every cycle against a window-based behavioural model.
module tb_key_hex_pio;
  localparam int NK = 4;
  localparam int NH = 6;
  localparam int DC = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     address = '0;
  logic           read = 1'b0;
  logic           write = 1'b0;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic           irq;
  logic [NK-1:0]  key_n = '1;
  logic [7*NH-1:0] hex_n;

  always #5 clk = ~clk;

  key_hex_pio #(.NUM_KEYS(NK), .NUM_HEX(NH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .key_n(key_n), .hex_n(hex_n)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] seg_ref [16];

  // Model: a key's accepted level flips once the last DC synchronised samples all disagree with it.
  logic [NK-1:0] m_d1, m_d2, m_state, m_edge, m_mask;
  logic [DC-1:0] m_hist [NK];
  logic [NH-1:0] m_mode;
  logic [6:0]    m_data [NH];
  logic [31:0]   m_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [3:0] a);
    logic [31:0] r;
    int idx;
    r = '0;
    idx = int'(a) - 4;
    if (a == 4'd0) r[NK-1:0] = m_state;
    else if (a == 4'd1) r[NK-1:0] = m_edge;
    else if (a == 4'd2) r[NK-1:0] = m_mask;
    else if (a == 4'd3) r[NH-1:0] = m_mode;
    else if (idx < NH) r[6:0] = m_data[idx];
    return r;
  endfunction

  function automatic logic [7*NH-1:0] m_hex();
    logic [7*NH-1:0] h;
    for (int i = 0; i < NH; i++)
      h[7*i +: 7] = m_mode[i] ? seg_ref[m_data[i][3:0]] : m_data[i];
    return h;
  endfunction

  task automatic model_step();
    logic [NK-1:0] s;
    int idx;
    if (reset) begin
      m_d1 = '1; m_d2 = '1; m_state = '0; m_edge = '0; m_mask = '0;
      m_mode = '1; m_rd = '0;
      for (int k = 0; k < NK; k++) m_hist[k] = '0;
      for (int i = 0; i < NH; i++) m_data[i] = '0;
    end else begin
      if (read) m_rd = m_reg(address);
      s = ~m_d2;
      m_d2 = m_d1;
      m_d1 = key_n;
      if (write && address == 4'd1) m_edge = m_edge & ~writedata[NK-1:0];
      for (int k = 0; k < NK; k++) begin
        m_hist[k] = {m_hist[k][DC-2:0], s[k]};
        if (m_hist[k] == {DC{~m_state[k]}}) begin
          if (!m_state[k]) m_edge[k] = 1'b1;
          m_state[k] = ~m_state[k];
        end
      end
      if (write) begin
        idx = int'(address) - 4;
        if (address == 4'd2) m_mask = writedata[NK-1:0];
        if (address == 4'd3) m_mode = writedata[NH-1:0];
        if (idx >= 0 && idx < NH) m_data[idx] = writedata[6:0];
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model_irq", {63'd0, irq}, {63'd0, |(m_edge & m_mask)});
    chk("model_readdata", {32'd0, readdata}, {32'd0, m_rd});
    chk("model_hex_n", {22'd0, hex_n}, {22'd0, m_hex()});
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    chk(nm, {32'd0, readdata}, {32'd0, exp});
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          dig;
    logic [6:0]  exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int n = 0; n < 16; n++) vecs.push_back('{4'd5, 32'(n), 1, seg_ref[n]});
    vecs.push_back('{4'd5, 32'h0A, 1, 7'h08});
    vecs.push_back('{4'd3, 32'h3D, 1, 7'h0A});
    vecs.push_back('{4'd5, 32'h7F, 1, 7'h7F});
    vecs.push_back('{4'd4, 32'h55, 0, 7'h12});
    vecs.push_back('{4'd3, 32'h00, 0, 7'h55});

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_hex", {22'd0, hex_n}, {22'd0, {NH{7'h40}}});
    chk("reset_irq", {63'd0, irq}, 64'd0);
    rd_chk("reset_state", 4'd0, 32'd0);
    rd_chk("reset_edge", 4'd1, 32'd0);
    rd_chk("reset_mask", 4'd2, 32'd0);
    rd_chk("reset_mode", 4'd3, 32'h3F);

    // Key 2 press: state rises exactly 2+DC edges after the falling input.
    key_n[2] = 1'b0;
    repeat (9) tick();
    rd_chk("press_state_edge10", 4'd0, 32'd0);
    rd_chk("press_state_after", 4'd0, 32'h4);
    rd_chk("press_edge", 4'd1, 32'h4);
    chk("press_irq_masked", {63'd0, irq}, 64'd0);
    bus_write(4'd2, 32'h4);
    chk("mask_irq_on", {63'd0, irq}, 64'd1);
    repeat (6) tick();
    key_n[2] = 1'b1;
    repeat (12) tick();
    rd_chk("release_state", 4'd0, 32'd0);
    rd_chk("edge_sticky", 4'd1, 32'h4);
    bus_write(4'd1, 32'h4);
    chk("w1c_irq_off", {63'd0, irq}, 64'd0);
    rd_chk("w1c_edge", 4'd1, 32'd0);

    // Clear lands on the same edge as a new press qualifying.
    key_n[2] = 1'b0;
    repeat (9) tick();
    bus_write(4'd1, 32'h4);
    rd_chk("set_wins_edge", 4'd1, 32'h4);
    chk("set_wins_irq", {63'd0, irq}, 64'd1);
    bus_write(4'd1, 32'h4);
    chk("clear_irq_drop", {63'd0, irq}, 64'd0);
    rd_chk("clear_edge", 4'd1, 32'd0);
    key_n[2] = 1'b1;
    repeat (12) tick();

    // Bounce: two 7-cycle lows split by one high never qualify.
    key_n[0] = 1'b0; repeat (7) tick();
    key_n[0] = 1'b1; tick();
    key_n[0] = 1'b0; repeat (7) tick();
    key_n[0] = 1'b1; repeat (12) tick();
    rd_chk("bounce_state", 4'd0, 32'd0);
    rd_chk("bounce_edge", 4'd1, 32'd0);

    foreach (vecs[j]) begin
      bus_write(vecs[j].addr, vecs[j].data);
      chk($sformatf("hex_vec%0d", j), {57'd0, hex_n[7*vecs[j].dig +: 7]}, {57'd0, vecs[j].exp});
    end

    rd_chk("unmapped_rd10", 4'd10, 32'd0);
    rd_chk("unmapped_rd15", 4'd15, 32'd0);
    bus_write(4'd15, 32'hFFFF_FFFF);
    bus_write(4'd10, 32'hFFFF_FFFF);
    bus_write(4'd0, 32'hFFFF_FFFF);
    chk("unmapped_hex", {22'd0, hex_n}, {22'd0, {4{7'h00}}, 7'h7F, 7'h55});
    rd_chk("unmapped_mode", 4'd3, 32'd0);
    rd_chk("unmapped_mask", 4'd2, 32'h4);
    rd_chk("ro_state", 4'd0, 32'd0);

    // Simultaneous read and write: old value returned, new value stored.
    address = 4'd4; writedata = 32'h11; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    chk("rw_old_value", {32'd0, readdata}, 64'h55);
    rd_chk("rw_new_value", 4'd4, 32'h11);

    // Reset mid-debounce with key still held.
    key_n[1] = 1'b0;
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midreset_hex", {22'd0, hex_n}, {22'd0, {NH{7'h40}}});
    chk("midreset_irq", {63'd0, irq}, 64'd0);
    repeat (9) tick();
    rd_chk("requal_before", 4'd0, 32'd0);
    rd_chk("requal_state", 4'd0, 32'h2);
    rd_chk("requal_edge", 4'd1, 32'h2);
    key_n[1] = 1'b1;
    repeat (12) tick();

    for (int c = 0; c < 3000; c++) begin
      int r;
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 29) == 0) key_n[k] = ~key_n[k];
      r = $urandom_range(0, 7);
      read = (r < 3);
      write = (r >= 2 && r < 5);
      address = 4'($urandom_range(0, 15));
      writedata = $urandom;
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    read = 1'b0; write = 1'b0; reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
